// File: rtl/fir_stream_dma.sv
// fir_stream_dma: Wishbone-programmed DMA feeding a FIR x-stream and storing its y-stream.
// Define FIR_DMA_IRQ_EN to build the one-cycle completion interrupt on irq_o.
module fir_stream_dma #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_dat_i,
    input  logic [31:0]            wbs_adr_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic                   mem_rd_req,
    input  logic                   mem_rd_gnt,
    output logic [pADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [pDATA_WIDTH-1:0] mem_rd_data,
    output logic                   mem_wr_req,
    input  logic                   mem_wr_gnt,
    output logic [pADDR_WIDTH-1:0] mem_wr_addr,
    output logic [pDATA_WIDTH-1:0] mem_wr_data,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    input  logic                   sm_tready,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    output logic                   irq_o
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] DEPTH = CW1'(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic [31:0] src, dst, rd_val;
    logic [15:0] len, len_m1, rd_issued, x_sent, out_cnt, y_idx;
    logic        done, err, inflight, wr_pending;
    logic [pDATA_WIDTH-1:0] fifo [FIFO_DEPTH];
    logic [pDATA_WIDTH-1:0] wr_buf;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [2:0]    sel;
    logic wb_req, wb_wr, start, run, push;
    logic rd_fire, x_fire, y_fire, w_fire, last_wr, done_set;
    logic unused;

    assign unused = ^{wbs_sel_i, wbs_adr_i[31:5], wbs_adr_i[1:0]};

    assign sel    = wbs_adr_i[4:2];
    assign wb_req = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign wb_wr  = wb_req & wbs_we_i;
    assign run    = (state == RUN);
    assign start  = wb_wr & (sel == 3'd0) & wbs_dat_i[0] & ~run;
    assign len_m1 = len - 16'd1;

    // Credit check counts the beat still in the memory pipe so the FIFO never overflows.
    assign mem_rd_req = run & (rd_issued < len)
                      & (({1'b0, count} + CW1'(inflight)) < DEPTH);
    assign mem_rd_addr = pADDR_WIDTH'(src) + pADDR_WIDTH'(rd_issued);
    assign rd_fire     = mem_rd_req & mem_rd_gnt;
    assign push        = run & inflight;

    assign sm_tvalid = run & (count != '0);
    assign sm_tdata  = sm_tvalid ? fifo[rd_ptr] : '0;
    assign sm_tlast  = sm_tvalid & (x_sent == len_m1);
    assign x_fire    = sm_tvalid & sm_tready;

    assign y_idx     = out_cnt + {15'd0, wr_pending};
    assign ss_tready = run
                     & (({1'b0, out_cnt} + {16'd0, wr_pending}) < {1'b0, len})
                     & (~wr_pending | mem_wr_gnt);
    assign y_fire    = ss_tvalid & ss_tready;

    assign mem_wr_req  = wr_pending;
    assign mem_wr_addr = pADDR_WIDTH'(dst) + pADDR_WIDTH'(out_cnt);
    assign mem_wr_data = wr_buf;
    assign w_fire      = wr_pending & mem_wr_gnt;
    assign last_wr     = (out_cnt == len_m1);
    assign done_set    = (start & (len == 16'd0)) | (w_fire & last_wr);

    always_comb begin
        rd_val = 32'd0;
        case (sel)
            3'd0: rd_val = {28'd0, err, run, done, 1'b0};
            3'd1: rd_val = src;
            3'd2: rd_val = dst;
            3'd3: rd_val = {16'd0, len};
            3'd4: rd_val = {16'd0, out_cnt};
            default: rd_val = 32'd0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && len != 16'd0) state_nxt = RUN;
            RUN:     if (w_fire && last_wr) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= mem_rd_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= 32'd0;
            src        <= 32'd0;
            dst        <= 32'd0;
            len        <= 16'd0;
            done       <= 1'b0;
            err        <= 1'b0;
            rd_issued  <= 16'd0;
            x_sent     <= 16'd0;
            out_cnt    <= 16'd0;
            inflight   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            wr_pending <= 1'b0;
            wr_buf     <= '0;
        end else begin
            wbs_ack_o <= wb_req;
            if (wb_req && !wbs_we_i) wbs_dat_o <= rd_val;
            if (wb_wr && !run) begin
                case (sel)
                    3'd1:    src <= wbs_dat_i;
                    3'd2:    dst <= wbs_dat_i;
                    3'd3:    len <= wbs_dat_i[15:0];
                    default: ;
                endcase
            end
            if (start) begin
                done       <= (len == 16'd0);
                err        <= 1'b0;
                rd_issued  <= 16'd0;
                x_sent     <= 16'd0;
                out_cnt    <= 16'd0;
                inflight   <= 1'b0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                wr_pending <= 1'b0;
            end else begin
                inflight <= rd_fire;
                if (rd_fire) rd_issued <= rd_issued + 16'd1;
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (x_fire) begin
                    rd_ptr <= rd_ptr + PW'(1);
                    x_sent <= x_sent + 16'd1;
                end
                count <= count + CW'(push) - CW'(x_fire);
                // A new beat may overwrite the holding slot in the cycle it drains.
                if (y_fire) begin
                    wr_buf     <= ss_tdata;
                    wr_pending <= 1'b1;
                    if (ss_tlast != (y_idx == len_m1)) err <= 1'b1;
                end else if (w_fire) begin
                    wr_pending <= 1'b0;
                end
                if (w_fire) out_cnt <= out_cnt + 16'd1;
                if (done_set) done <= 1'b1;
            end
        end
    end

`ifdef FIR_DMA_IRQ_EN
    always_ff @(posedge clk) begin
        if (!rst_n) irq_o <= 1'b0;
        else        irq_o <= done_set;
    end
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: doc/fir_stream_dma.md
Name: fir_stream_dma

Overview:
- Initiator-side companion to the FIR/MM accelerator's stream interfaces.
- Fetches LEN input samples from a word-addressed sample memory and drives them as an AXI-Stream master into the accelerator's x-input.
- Accepts the accelerator's y-output as an AXI-Stream slave and writes each result to a destination buffer.
- Configured and polled by firmware over Wishbone.

Parameters:
pADDR_WIDTH, 12, word-address width of sample memory ports
pDATA_WIDTH, 32, sample/result width
FIFO_DEPTH, 4, read-data prefetch FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte enables (ignored, full-word access only)
wbs_dat_i  in  32  write data
wbs_adr_i  in  32  address; [4:2] selects register
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
mem_rd_req  out  1  read request
mem_rd_gnt  in  1  read grant
mem_rd_addr  out  pADDR_WIDTH  read word address
mem_rd_data  in  pDATA_WIDTH  read data, valid exactly 1 cycle after req&gnt
mem_wr_req  out  1  write request
mem_wr_gnt  in  1  write grant (write completes on req&gnt)
mem_wr_addr  out  pADDR_WIDTH  write word address
mem_wr_data  out  pDATA_WIDTH  write data
sm_tvalid  out  1  x-stream valid (to accelerator ss_tvalid)
sm_tdata  out  pDATA_WIDTH  x-stream data
sm_tlast  out  1  x-stream last
sm_tready  in  1  x-stream ready
ss_tvalid  in  1  y-stream valid (from accelerator sm_tvalid)
ss_tdata  in  pDATA_WIDTH  y-stream data
ss_tlast  in  1  y-stream last
ss_tready  out  1  y-stream ready
irq_o  out  1  completion interrupt

Behaviour:
- Reset values: all outputs 0; state IDLE; registers, counters and FIFO cleared. Reset mid-run drops outstanding requests and the FIFO. No write is issued after reset.
- Registers (word offsets):
  - 0x00 CTRL: [0] start, write-1, self-clearing, reads 0; [1] done, RO, sticky; [2] busy, RO; [3] err, RO, sticky.
  - 0x04 SRC base; 0x08 DST base; 0x0C LEN [15:0]; 0x10 OUT_CNT RO.
- Wishbone: ack registered, high exactly 1 cycle after stb&cyc, then low for at least 1 cycle. Reads return the register; unmapped offsets read 0. SRC/DST/LEN writes are ignored while busy.
- States: IDLE -> RUN on start with LEN>0 (clears done/err/counters). Start with LEN=0 sets done the next cycle, with no stream traffic. Start while busy is ignored.
- Read engine:
  - mem_rd_req asserts while rd_issued<LEN and (fifo_count+inflight)<FIFO_DEPTH.
  - Address = SRC+rd_issued, wrapping modulo 2^pADDR_WIDTH.
  - Returned data is pushed into the FIFO.
- x-stream:
  - sm_tvalid = RUN & FIFO non-empty; sm_tdata = FIFO head.
  - sm_tlast = sm_tvalid & (x_sent==LEN-1).
  - Data/last are held stable while tvalid&!tready; pop on tvalid&tready.
  - Back-to-back beats at 1/cycle when memory grants every cycle.
- y-stream:
  - ss_tready = RUN & (out_cnt+pending<LEN) & (!wr_pending | mem_wr_gnt).
  - A handshake loads a 1-entry holding register and raises mem_wr_req, held until gnt.
  - Address = DST+out_cnt (wrapping); out_cnt increments on gnt.
  - Simultaneous gnt and new handshake: the new beat replaces the holding register the same cycle, giving 1/cycle throughput.
- tlast check:
  - ss_tlast on beat index != LEN-1 sets err.
  - Missing ss_tlast on beat LEN-1 sets err.
  - Counting continues in both cases.
- Completion: when out_cnt reaches LEN, RUN -> IDLE, done=1, busy=0. After completion ss_tready=0 and no further writes.
- Arithmetic: counters are 16-bit; address adds are truncated to pADDR_WIDTH.

Optional Feature:
FIR_DMA_IRQ_EN:
- Defined: irq_o pulses high exactly 1 cycle in the cycle done rises, including the LEN=0 case.
- Undefined: irq_o tied 0 and the irq logic is not compiled.

Test Plan:
- LEN=11, SRC=0x100, DST=0x200, memory grants every cycle, sm_tready=1, accelerator echoes input -> 11 x-beats with tlast on the 11th; DST 0x200..0x20A equal SRC data; done=1, err=0, OUT_CNT=11.
- LEN=8, sm_tready toggles 1-cycle-on/2-cycles-off, mem_rd_gnt random -> no beat dropped or duplicated, sm_tdata stable during stalls, FIFO never exceeds 4 entries.
- LEN=5, y-stream with ss_tlast on beat 2 and none on beat 4 -> err=1, all 5 results written, done=1.
- LEN=0, start -> done=1 the next cycle, no mem_rd_req, no sm_tvalid; irq_o pulse iff FIR_DMA_IRQ_EN.
- SRC=0xFFE, LEN=4 -> read addresses 0xFFE, 0xFFF, 0x000, 0x001.
- rst_n low for 1 cycle at x_sent=3 of LEN=10 -> all outputs 0, busy=0, no write after reset; a new start then completes normally.
